bomba_esvaziamento: RTL and testbench

//  Drain-side pump controller: empties the tank that the fill pump (bomba_1) feeds, moving water onward to a destination tank.

---
 rtl/bomba_pkg.sv | 19 +
 rtl/bomba_esvaziamento_filtro_sensor.sv | 27 ++
 rtl/bomba_esvaziamento.sv | 47 ++++
 tb/tb_bomba_esvaziamento.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/bomba_pkg.sv
// bomba_pkg: state encodings and level-table next-state function shared by the pump controllers
package bomba_pkg;
  localparam logic [2:0] VAZIO      = 3'd0;
  localparam logic [2:0] ENCHENDO   = 3'd1;
  localparam logic [2:0] CHEIO      = 3'd2;
  localparam logic [2:0] ESVAZIANDO = 3'd3;
  localparam logic [2:0] FALHA      = 3'd4;
  // n = {low sensor, high sensor}; 01 (high wet, low dry) is always a sensor fault
  function automatic logic [2:0] prox_estado(input logic [2:0] e, input logic [1:0] n);
    if (n == 2'b01) return FALHA;
    case (e)
      VAZIO:      return n == 2'b10 ? ENCHENDO : n == 2'b11 ? FALHA : VAZIO;
      ENCHENDO:   return n == 2'b11 ? CHEIO : n == 2'b00 ? VAZIO : ENCHENDO;
      CHEIO:      return n == 2'b10 ? ESVAZIANDO : n == 2'b00 ? FALHA : CHEIO;
      ESVAZIANDO: return n == 2'b00 ? VAZIO : n == 2'b11 ? CHEIO : ESVAZIANDO;
      default:    return n == 2'b00 ? VAZIO : n == 2'b10 ? ENCHENDO : CHEIO;
    endcase
  endfunction
endpackage

// File: rtl/bomba_esvaziamento_filtro_sensor.sv
// filtro_sensor: 2-FF synchroniser plus debounce; filt follows the input after DEB_CICLOS stable cycles
module filtro_sensor #(
  parameter int DEB_CICLOS = 4,
  parameter int LARG_CONT  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt
);
  logic [1:0] sinc;
  logic [LARG_CONT-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sinc <= '0;
      filt <= 1'b0;
      cnt  <= '0;
    end else begin
      sinc <= {sinc[0], raw};
      if (sinc[1] == filt) cnt <= '0;
      else if (cnt == LARG_CONT'(DEB_CICLOS - 1)) begin
        filt <= sinc[1];
        cnt  <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/bomba_esvaziamento.sv
// bomba_esvaziamento: drain pump controller with level FSM, anti-short-cycle timer; ALARME_TRAVADO_EN latches FALHA until ack
module bomba_esvaziamento
  import bomba_pkg::*;
#(
  parameter int DEB_CICLOS = 4,
  parameter int T_MIN_DESL = 8,
  parameter int LARG_CONT  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s1,
  input  logic s2,
  input  logic alarme_b1,
  input  logic cheio_dest,
  input  logic ack,
  output logic m2,
  output logic alarme
);
  logic n1, n2, m2_prox;
  logic [2:0] estado, prox;
  logic [LARG_CONT-1:0] tmr, tmr_dec;
  filtro_sensor #(.DEB_CICLOS(DEB_CICLOS), .LARG_CONT(LARG_CONT)) u_f1 (.clk, .rst_n, .raw(s1), .filt(n1));
  filtro_sensor #(.DEB_CICLOS(DEB_CICLOS), .LARG_CONT(LARG_CONT)) u_f2 (.clk, .rst_n, .raw(s2), .filt(n2));
`ifdef ALARME_TRAVADO_EN
  assign prox = (estado == FALHA && !ack) ? FALHA : prox_estado(estado, {n1, n2});
`else
  logic unused_ack;
  assign unused_ack = ack;
  assign prox = prox_estado(estado, {n1, n2});
`endif
  // gate on the post-decrement value so the motor is off exactly T_MIN_DESL cycles
  assign tmr_dec = tmr - LARG_CONT'(tmr != '0);
  assign m2_prox = (prox == CHEIO || prox == ESVAZIANDO) && !alarme_b1 && !cheio_dest && tmr_dec == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= VAZIO;
      m2     <= 1'b0;
      alarme <= 1'b0;
      tmr    <= LARG_CONT'(T_MIN_DESL);
    end else begin
      estado <= prox;
      alarme <= prox == FALHA;
      m2     <= m2_prox;
      tmr    <= (m2 && !m2_prox) ? LARG_CONT'(T_MIN_DESL) : tmr_dec;
    end
  end
endmodule

// File: tb/tb_bomba_esvaziamento.sv
// tb_bomba_esvaziamento: scoreboard bench; expected {m2,alarme} queued with due cycle, compared at negedge
module tb_bomba_esvaziamento;
  import bomba_pkg::*;
  logic clk = 0, rst_n = 0, s1 = 0, s2 = 0, alarme_b1 = 0, cheio_dest = 0, ack = 0;
  logic m2, alarme;
  int cyc = 0, n_chk = 0, n_fail = 0;
  typedef struct {int due; string tag; logic [1:0] exp;} item_t;
  item_t sb[$];

  bomba_esvaziamento dut (.clk(clk), .rst_n(rst_n), .s1(s1), .s2(s2), .alarme_b1(alarme_b1),
                          .cheio_dest(cheio_dest), .ack(ack), .m2(m2), .alarme(alarme));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk)
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].due == cyc) begin
        chk(sb[i].tag, 4'({m2, alarme}), 4'(sb[i].exp));
        sb.delete(i);
      end

  task automatic exp_at(input int d, input string tag, input logic [1:0] e);
    sb.push_back('{cyc + d, tag, e});
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_s(input logic [1:0] v);
    {s1, s2} = v;
  endtask

  initial begin
    step(3);
    chk("rst_out", 4'({m2, alarme}), 4'b0000);
    chk("rst_estado", 4'(dut.estado), 4'(VAZIO));
    rst_n = 1;
    // idle at empty
    exp_at(5, "t1_idle", 2'b00);
    exp_at(19, "t1_idle_end", 2'b00);
    step(20);
    chk("t1_estado", 4'(dut.estado), 4'(VAZIO));
    // full fill/drain cycle
    set_s(2'b10);
    step(10);
    chk("t2_enchendo", 4'(dut.estado), 4'(ENCHENDO));
    set_s(2'b11);
    exp_at(6, "t2_m2_pre", 2'b00);
    exp_at(7, "t2_m2_on", 2'b10);
    step(10);
    chk("t2_cheio", 4'(dut.estado), 4'(CHEIO));
    set_s(2'b10);
    exp_at(7, "t2_drain", 2'b10);
    step(10);
    chk("t2_esvaziando", 4'(dut.estado), 4'(ESVAZIANDO));
    set_s(2'b00);
    exp_at(6, "t2_m2_hold", 2'b10);
    exp_at(7, "t2_m2_off", 2'b00);
    step(10);
    chk("t2_vazio", 4'(dut.estado), 4'(VAZIO));
    // sensor fault while draining
    set_s(2'b10);
    step(10);
    set_s(2'b11);
    exp_at(7, "t3_on", 2'b10);
    step(10);
    set_s(2'b10);
    step(10);
    set_s(2'b01);
    exp_at(6, "t3_pre", 2'b10);
    exp_at(7, "t3_falha", 2'b01);
    step(10);
    chk("t3_estado_falha", 4'(dut.estado), 4'(FALHA));
    set_s(2'b10);
`ifdef ALARME_TRAVADO_EN
    exp_at(7, "t3_latched", 2'b01);
    step(10);
    chk("t3_still_falha", 4'(dut.estado), 4'(FALHA));
    ack = 1;
    exp_at(0, "t3_ack_pre", 2'b01);
    exp_at(1, "t3_ack", 2'b00);
    step(1);
    ack = 0;
    step(2);
`else
    exp_at(6, "t3_clear_pre", 2'b01);
    exp_at(7, "t3_clear", 2'b00);
    step(10);
`endif
    chk("t3_enchendo", 4'(dut.estado), 4'(ENCHENDO));
    // interlock pulses and minimum off time
    set_s(2'b11);
    exp_at(7, "t4_on", 2'b10);
    step(10);
    set_s(2'b10);
    step(10);
    alarme_b1 = 1;
    exp_at(0, "t4_pre", 2'b10);
    exp_at(1, "t4_off", 2'b00);
    step(3);
    alarme_b1 = 0;
    exp_at(5, "t4_held", 2'b00);
    exp_at(6, "t4_back", 2'b10);
    step(10);
    cheio_dest = 1;
    exp_at(1, "t4_dest_off", 2'b00);
    step(1);
    cheio_dest = 0;
    exp_at(7, "t4_dest_held", 2'b00);
    exp_at(8, "t4_dest_back", 2'b10);
    step(12);
    // debounce: 3-cycle glitch ignored, 4-cycle accepted
    exp_at(6, "t5_g3_a", 2'b10);
    exp_at(7, "t5_g3_b", 2'b10);
    exp_at(10, "t5_g3_c", 2'b10);
    set_s(2'b00);
    step(3);
    set_s(2'b10);
    step(12);
    chk("t5_g3_estado", 4'(dut.estado), 4'(ESVAZIANDO));
    exp_at(6, "t5_g4_pre", 2'b10);
    exp_at(7, "t5_g4_acc", 2'b00);
    set_s(2'b00);
    step(4);
    set_s(2'b10);
    step(12);
    chk("t5_g4_estado", 4'(dut.estado), 4'(ENCHENDO));
    // async reset mid-drain
    set_s(2'b11);
    exp_at(7, "t6_on", 2'b10);
    step(10);
    chk("t6_pre_rst", 4'(m2), 4'(1));
    rst_n = 0;
    set_s(2'b00);
    #1;
    chk("t6_async_out", 4'({m2, alarme}), 4'b0000);
    chk("t6_async_estado", 4'(dut.estado), 4'(VAZIO));
    step(2);
    rst_n = 1;
    for (int d = 1; d <= 10; d++) exp_at(d, "t6_hold", 2'b00);
    step(12);
    chk("sb_empty", 4'(sb.size() != 0), 4'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
